// File: rtl/sd_pkg.sv
// Shared SD-reader definitions: byte width, card/filesystem encodings and
// the byte-lane mapping used when packing file bytes into wider words.
package sd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    CARD_UNKNOWN = 2'd0,
    CARD_SDV1    = 2'd1,
    CARD_SDV2    = 2'd2,
    CARD_SDHCV2  = 2'd3
  } card_type_t;

  typedef enum logic [1:0] {
    FS_UNASSIGNED = 2'd0,
    FS_UNKNOWN    = 2'd1,
    FS_FAT16      = 2'd2,
    FS_FAT32      = 2'd3
  } filesystem_type_t;

  // Lane 0 is the LSB; big-endian packing puts the first byte in the top lane.
  function automatic int lane_of(input int idx, input int bpw, input bit big_endian);
    return big_endian ? (bpw - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/sd_sync_fifo.sv
// Single-clock FIFO with full/empty/level. A push while full is accepted only
// when a pop happens in the same cycle; the read port shows zero when empty.
module sd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sd_word_packer.sv
// Packs the file-reader byte stream into BYTES_PER_WORD-byte words with keep
// mask and end-of-file flush, buffered in a FIFO. Optional per-file checksum
// output is enabled with SD_WORD_PACKER_CHECKSUM_EN.
module sd_word_packer
  import sd_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int BIG_ENDIAN     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [BYTE_W-1:0]             in_byte,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] out_word,
  output logic [BYTES_PER_WORD-1:0]     out_keep,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
`ifdef SD_WORD_PACKER_CHECKSUM_EN
  ,
  output logic [15:0]                   csum,
  output logic                          csum_valid
`endif
);
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int FIFO_W = WORD_W + BYTES_PER_WORD + 1;

  logic [IDX_W-1:0]          idx;
  logic [WORD_W-1:0]         asm_word;
  logic [BYTES_PER_WORD-1:0] asm_keep;
  logic [WORD_W-1:0]         merged_word;
  logic [BYTES_PER_WORD-1:0] merged_keep;
  int                        lane;
  logic                      complete;
  logic                      drop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_W-1:0]         fifo_rdata;

  // Incoming byte merged with the partial word; this is what a completing byte pushes.
  always_comb begin
    lane        = lane_of(32'(idx), BYTES_PER_WORD, BIG_ENDIAN != 0);
    merged_word = asm_word;
    merged_keep = asm_keep;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i == lane) begin
        merged_word[i*BYTE_W +: BYTE_W] = in_byte;
        merged_keep[i]                  = 1'b1;
      end
    end
  end

  assign complete = in_valid && ((idx == IDX_W'(BYTES_PER_WORD - 1)) || in_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      asm_word <= '0;
      asm_keep <= '0;
    end else if (complete) begin
      idx      <= '0;
      asm_word <= '0;
      asm_keep <= '0;
    end else if (in_valid) begin
      idx      <= idx + 1'b1;
      asm_word <= merged_word;
      asm_keep <= merged_keep;
    end
  end

  // Output handshake: a word transfers on a cycle with out_valid && out_ready;
  // out_valid is the registered FIFO non-empty state and never looks at
  // out_ready, and the head word holds while out_valid && !out_ready.
  sd_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (complete),
    .wdata ({merged_word, merged_keep, in_last}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid                      = !fifo_empty;
  assign {out_word, out_keep, out_last} = fifo_rdata;

  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign drop = complete && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

`ifdef SD_WORD_PACKER_CHECKSUM_EN
  logic [15:0] csum_acc;
  logic [15:0] csum_next;

  assign csum_next = csum_acc + 16'(in_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_acc   <= '0;
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= 1'b0;
      if (in_valid) begin
        if (in_last) begin
          csum       <= csum_next;
          csum_valid <= 1'b1;
          csum_acc   <= '0;
        end else begin
          csum_acc <= csum_next;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sd_word_packer.sv
// Bench for sd_word_packer: big- and little-endian instances share one stimulus
// stream and are compared every cycle against a queue-based packing model.
module tb_sd_word_packer;
  localparam int BPW   = 3;
  localparam int DEPTH = 4;
  localparam int WW    = 8 * BPW;
  // Entry layout: {be_word, le_word, be_keep, le_keep, last}
  localparam int W     = 2 * WW + 2 * BPW + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [7:0]     in_byte;
  logic           in_last;
  logic           out_ready;

  logic           out_valid_be, out_valid_le;
  logic [WW-1:0]  out_word_be, out_word_le;
  logic [BPW-1:0] out_keep_be, out_keep_le;
  logic           out_last_be, out_last_le;
  logic [2:0]     level_be, level_le;
  logic           overflow_be, overflow_le;
  logic [15:0]    drop_count_be, drop_count_le;
`ifdef SD_WORD_PACKER_CHECKSUM_EN
  logic [15:0]    csum_be, csum_le;
  logic           csum_valid_be, csum_valid_le;
`endif

  sd_word_packer #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
    .out_valid(out_valid_be), .out_ready(out_ready), .out_word(out_word_be),
    .out_keep(out_keep_be), .out_last(out_last_be), .level(level_be),
    .overflow(overflow_be), .drop_count(drop_count_be)
`ifdef SD_WORD_PACKER_CHECKSUM_EN
    , .csum(csum_be), .csum_valid(csum_valid_be)
`endif
  );

  sd_word_packer #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
    .out_valid(out_valid_le), .out_ready(out_ready), .out_word(out_word_le),
    .out_keep(out_keep_le), .out_last(out_last_le), .level(level_le),
    .overflow(overflow_le), .drop_count(drop_count_le)
`ifdef SD_WORD_PACKER_CHECKSUM_EN
    , .csum(csum_le), .csum_valid(csum_valid_le)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit armed    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   cur_bytes[$];
  logic         m_overflow;
  logic [15:0]  m_drops;
  logic [15:0]  m_sum;
  logic [15:0]  m_csum;
  logic         m_csv;

  always @(posedge clk) begin
    logic [WW-1:0]  be, le;
    logic [BPW-1:0] be_keep, le_keep;
    int n;
    if (reset) begin
      exp_q.delete();
      cur_bytes.delete();
      m_overflow = 1'b0;
      m_drops    = '0;
      m_sum      = '0;
      m_csum     = '0;
      m_csv      = 1'b0;
    end else begin
      m_csv = 1'b0;
      if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid) begin
        m_sum = m_sum + 16'(in_byte);
        if (in_last) begin
          m_csum = m_sum;
          m_sum  = '0;
          m_csv  = 1'b1;
        end
        cur_bytes.push_back(in_byte);
        if (cur_bytes.size() == BPW || in_last) begin
          n  = cur_bytes.size();
          be = '0;
          le = '0;
          foreach (cur_bytes[k]) begin
            be = {be[WW-9:0], cur_bytes[k]};
            le[8*k +: 8] = cur_bytes[k];
          end
          be      = be << (8 * (BPW - n));
          le_keep = BPW'((1 << n) - 1);
          be_keep = BPW'(((1 << n) - 1) << (BPW - n));
          if (exp_q.size() < DEPTH) exp_q.push_back({be, le, be_keep, le_keep, in_last});
          else begin
            m_overflow = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
          end
          cur_bytes.delete();
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] head;
    if (armed) begin
      check("out_valid_be", out_valid_be, exp_q.size() > 0);
      check("out_valid_le", out_valid_le, exp_q.size() > 0);
      check("level_be", level_be, exp_q.size());
      check("level_le", level_le, exp_q.size());
      check("overflow_be", overflow_be, m_overflow);
      check("overflow_le", overflow_le, m_overflow);
      check("drop_count_be", drop_count_be, m_drops);
      check("drop_count_le", drop_count_le, m_drops);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("word_be", out_word_be, head[W-1 -: WW]);
        check("word_le", out_word_le, head[W-1-WW -: WW]);
        check("keep_be", out_keep_be, head[2*BPW:BPW+1]);
        check("keep_le", out_keep_le, head[BPW:1]);
        check("last_be", out_last_be, head[0]);
        check("last_le", out_last_le, head[0]);
      end
`ifdef SD_WORD_PACKER_CHECKSUM_EN
      check("csum_valid", csum_valid_be, m_csv);
      if (m_csv) check("csum", csum_be, m_csum);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] b, input logic l, input logic r);
    in_valid  = v;
    in_byte   = b;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic idle(input logic r, input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 8'($urandom_range(0, 255)), 1'b0, r);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;

    check("rst_valid", out_valid_be, 1'b0);
    check("rst_level", level_be, 3'd0);
    check("rst_word", out_word_be, 24'h0);
    check("rst_keep", out_keep_be, 3'b000);
    check("rst_overflow", overflow_be, 1'b0);
    check("rst_drops", drop_count_be, 16'h0);

    // Full words streamed with the consumer always ready
    drive(1, 8'h11, 0, 1); drive(1, 8'h22, 0, 1); drive(1, 8'h33, 0, 1);
    check("t1_word0", out_word_be, 24'h112233);
    check("t1_keep0", out_keep_be, 3'b111);
    drive(1, 8'h44, 0, 1); drive(1, 8'h55, 0, 1); drive(1, 8'h66, 0, 1);
    check("t1_word1", out_word_be, 24'h445566);
    check("t1_word1_le", out_word_le, 24'h665544);
    idle(1, 2);

    // Partial word flushed by in_last
    drive(1, 8'hAA, 0, 1); drive(1, 8'hBB, 1, 1);
    check("t2_word_le", out_word_le, 24'h00BBAA);
    check("t2_keep_le", out_keep_le, 3'b011);
    check("t2_last", out_last_le, 1'b1);
    check("t2_word_be", out_word_be, 24'hAABB00);
    check("t2_keep_be", out_keep_be, 3'b110);
    idle(1, 2);

    // Full FIFO with push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 12; i++) drive(1, 8'(i + 1), 0, 0);
    check("t3_level_full", level_be, 3'd4);
    drive(1, 8'd13, 0, 0); drive(1, 8'd14, 0, 0); drive(1, 8'd15, 0, 1);
    check("t3_level", level_be, 3'd4);
    check("t3_overflow", overflow_be, 1'b0);
    check("t3_drops", drop_count_be, 16'd0);
    check("t3_head", out_word_be, 24'h040506);
    idle(1, 6);

    // Overflow: five words into a four-entry FIFO while stalled
    do_reset();
    for (int i = 0; i < 15; i++) drive(1, 8'(i + 1), 0, 0);
    check("t4_level", level_be, 3'd4);
    check("t4_overflow", overflow_be, 1'b1);
    check("t4_drops", drop_count_be, 16'd1);
    check("t4_head", out_word_be, 24'h010203);
    idle(0, 3);
    check("t4_head_held", out_word_be, 24'h010203);
    idle(1, 6);
    check("t4_drained", level_be, 3'd0);
    check("t4_overflow_sticky", overflow_be, 1'b1);

    // Reset mid-word discards the partial word
    drive(1, 8'h77, 0, 0); drive(1, 8'h88, 0, 0);
    do_reset();
    drive(1, 8'h01, 0, 0); drive(1, 8'h02, 0, 0); drive(1, 8'h03, 0, 0);
    check("t5_level", level_be, 3'd1);
    check("t5_word", out_word_be, 24'h010203);
    check("t5_keep", out_keep_be, 3'b111);
    idle(1, 3);

`ifdef SD_WORD_PACKER_CHECKSUM_EN
    do_reset();
    drive(1, 8'hFF, 0, 1); drive(1, 8'hFF, 0, 1); drive(1, 8'h02, 1, 1);
    check("t6_csum_valid", csum_valid_be, 1'b1);
    check("t6_csum", csum_be, 16'h0200);
    idle(1, 1);
    check("t6_csum_pulse", csum_valid_be, 1'b0);
`endif

    // Randomised traffic with varying consumer stall rates
    for (int phase = 0; phase < 4; phase++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 599) == 0) do_reset();
        else drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) <= phase));
      end
    end
    idle(1, 10);
    check("final_level", level_be, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
